// File: rtl/puf_chal_seq.sv
// -----------------------------------------------------------------------------
// puf_chal_seq
//
// Challenge sequencer for the RO PUF. It seeds and steps an external LFSR to
// produce NUM_CHAL challenges. Each challenge is offered to the PUF
// measurement core over a valid/ready handshake. The returned response bits
// are shifted into one response word, and the end of the run is signalled
// with a one-cycle done pulse.
//
// Parameters
//   NUM_BITS  LFSR / challenge width (3..32); must match the attached LFSR
//   NUM_CHAL  challenges and response bits per run (2..256)
//   STEPS     LFSR advances between consecutive challenges (1..16)
//   TIMEOUT   response wait limit in cycles (only with PUF_CHAL_TIMEOUT_EN)
//
// Optional feature macro: PUF_CHAL_TIMEOUT_EN
//   Defined   : a WAIT that sees no response for TIMEOUT cycles aborts the
//               run with a sticky timeout_err.
//   Undefined : WAIT waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start, seed           run request and run seed (sampled in IDLE)
//   busy, done            run in progress (through done); end-of-run pulse
//   response              collected bits, first bit ends in the MSB
//   timeout_err           sticky run-abort flag
//   lfsr_en, lfsr_seed_DV, lfsr_seed, lfsr_data   LFSR control / data
//   chal_valid, chal_ready, chal                  challenge handshake
//   resp_valid, resp_bit                          response strobe and bit
// -----------------------------------------------------------------------------
module puf_chal_seq #(
  parameter int NUM_BITS = 8,
  parameter int NUM_CHAL = 16,
  parameter int STEPS    = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] seed,
  output logic                busy,
  output logic                done,
  output logic [NUM_CHAL-1:0] response,
  output logic                timeout_err,
  output logic                lfsr_en,
  output logic                lfsr_seed_DV,
  output logic [NUM_BITS-1:0] lfsr_seed,
  input  logic [NUM_BITS-1:0] lfsr_data,
  output logic                chal_valid,
  input  logic                chal_ready,
  output logic [NUM_BITS-1:0] chal,
  input  logic                resp_valid,
  input  logic                resp_bit
);

  localparam int CW = $clog2(NUM_CHAL);
  localparam int SW = $clog2(STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_STEP  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [NUM_BITS-1:0] seed_r;
  logic [NUM_CHAL-1:0] response_r;
  logic [CW-1:0]       chal_cnt_r;
  logic [SW-1:0]       step_cnt_r;
  logic                busy_r;
  logic                done_r;
  logic                chal_valid_r;
  logic                lfsr_en_r;
  logic                lfsr_seed_dv_r;
  logic                start_acc_s;
  logic                capture_s;
  logic                last_chal_s;
  logic                steps_done_s;
  logic                timeout_hit_s;

  assign start_acc_s  = (state_r == S_IDLE) && start;
  assign capture_s    = (state_r == S_WAIT) && resp_valid;
  assign last_chal_s  = (chal_cnt_r == CW'(NUM_CHAL - 1));
  assign steps_done_s = (step_cnt_r == SW'(STEPS - 1));

`ifdef PUF_CHAL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wait_cnt_r;
  logic          timeout_err_r;

  // A response arriving in the limit cycle takes priority over the abort.
  assign timeout_hit_s = (state_r == S_WAIT) && !resp_valid &&
                         (wait_cnt_r == WW'(TIMEOUT - 1));

  // Wait counter (zero on WAIT entry) and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r    <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if ((state_r == S_WAIT) && !resp_valid) begin
        wait_cnt_r <= wait_cnt_r + WW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (start_acc_s) begin
        timeout_err_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT != 0);
  assign timeout_hit_s    = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_SEED;
        else       state_nxt_s = S_IDLE;
      end
      S_SEED: state_nxt_s = S_STEP;
      S_STEP: begin
        if (steps_done_s) state_nxt_s = S_ISSUE;
        else              state_nxt_s = S_STEP;
      end
      S_ISSUE: begin
        // chal_valid is high throughout ISSUE, so ready alone completes it.
        if (chal_ready) state_nxt_s = S_WAIT;
        else            state_nxt_s = S_ISSUE;
      end
      S_WAIT: begin
        if (capture_s) begin
          if (last_chal_s) state_nxt_s = S_DONE;
          else             state_nxt_s = S_STEP;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Seed latch, response shift register and challenge counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_r     <= '0;
      response_r <= '0;
      chal_cnt_r <= '0;
    end else if (start_acc_s) begin
      // All-ones is the XNOR LFSR lock-up value; substitute all-zeros.
      if (seed == {NUM_BITS{1'b1}}) seed_r <= {NUM_BITS{1'b0}};
      else                          seed_r <= seed;
      response_r <= '0;
      chal_cnt_r <= '0;
    end else if (capture_s) begin
      response_r <= {response_r[NUM_CHAL-2:0], resp_bit};
      chal_cnt_r <= chal_cnt_r + CW'(1);
    end else begin
      seed_r     <= seed_r;
      response_r <= response_r;
      chal_cnt_r <= chal_cnt_r;
    end
  end

  // Step counter: restarts at zero on every entry into STEP.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_r <= '0;
    end else if (state_r == S_STEP) begin
      step_cnt_r <= step_cnt_r + SW'(1);
    end else begin
      step_cnt_r <= '0;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      chal_valid_r   <= 1'b0;
      lfsr_en_r      <= 1'b0;
      lfsr_seed_dv_r <= 1'b0;
    end else begin
      busy_r         <= (state_nxt_s != S_IDLE);
      done_r         <= (state_nxt_s == S_DONE);
      chal_valid_r   <= (state_nxt_s == S_ISSUE);
      lfsr_en_r      <= (state_nxt_s == S_SEED) || (state_nxt_s == S_STEP);
      lfsr_seed_dv_r <= (state_nxt_s == S_SEED);
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign chal_valid   = chal_valid_r;
  assign lfsr_en      = lfsr_en_r;
  assign lfsr_seed_DV = lfsr_seed_dv_r;
  // Seed stays on the bus in every state so the LFSR's compare is meaningful.
  assign lfsr_seed    = seed_r;
  assign chal         = lfsr_data;
  assign response     = response_r;

endmodule

// File: doc/puf_chal_seq.md
# puf_chal_seq

Challenge sequencer for the RO PUF. It seeds and steps an external `LFSR` instance to generate a run of `NUM_CHAL` challenges. Each challenge goes to the PUF measurement core over a valid/ready handshake. The returned response bits are collected into one response word, which is reported with a single-cycle `done` pulse.

## Interface
- `NUM_BITS`, 8 — LFSR / challenge width; must match the attached `LFSR` (3..32)
- `NUM_CHAL`, 16 — challenges (and response bits) per run, 2..256
- `STEPS`, 1 — LFSR advances between consecutive challenges, 1..16
- `TIMEOUT`, 1023 — response wait limit in cycles (used only with the macro)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `seed`  in  NUM_BITS  run seed; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle pulse at run end
- `response`  out  NUM_CHAL  collected response bits; first bit ends in MSB
- `timeout_err`  out  1  sticky run-abort flag
- `lfsr_en`  out  1  to LFSR `en`
- `lfsr_seed_DV`  out  1  to LFSR `seed_DV`
- `lfsr_seed`  out  NUM_BITS  to LFSR `seed`
- `lfsr_data`  in  NUM_BITS  from LFSR `LFSR_data`
- `chal_valid`  out  1  challenge offered to PUF core
- `chal_ready`  in  1  PUF core accepts challenge
- `chal`  out  NUM_BITS  challenge; equals `lfsr_data`
- `resp_valid`  in  1  response bit strobe from PUF core
- `resp_bit`  in  1  response bit

## Operation
- **State machine:** IDLE → SEED → STEP → ISSUE → WAIT → (STEP | DONE) → IDLE.
- **IDLE**
  - `start`=1 latches `seed` into `seed_r`, clears `response`, `timeout_err` and the challenge count, then goes to SEED.
  - An all-ones seed is the XNOR lock-up value, so it is replaced by all-zeros.
- **SEED** (1 cycle)
  - Drives `lfsr_en`=1, `lfsr_seed_DV`=1, `lfsr_seed`=`seed_r`.
  - Goes to STEP with step count 0.
  - `lfsr_seed` holds `seed_r` in all states, so the LFSR's `LFSR_done` compare stays meaningful.
- **STEP** (exactly `STEPS` cycles)
  - Drives `lfsr_en`=1, `lfsr_seed_DV`=0, then goes to ISSUE.
- **ISSUE**
  - Drives `chal_valid`=1 with `lfsr_en`=0, so `chal` is stable.
  - When `chal_valid`&&`chal_ready`, goes to WAIT.
- **WAIT**
  - On `resp_valid`: `response` <= {`response`[NUM_CHAL-2:0], `resp_bit`} and the count increments.
  - If the count was `NUM_CHAL`-1, goes to DONE; otherwise goes to STEP.
- **DONE** (1 cycle): `done`=1, then IDLE. `response` holds until the next accepted `start`.
- **Outputs:** `lfsr_en` is 1 only in SEED/STEP; `lfsr_seed_DV` is 1 only in SEED.
- **Ignored inputs:**
  - `start` outside IDLE.
  - `resp_valid` outside WAIT.
  - `chal_ready` outside ISSUE.

## Timing
- **Reset:**
  - State → IDLE.
  - `busy`, `done`, `chal_valid`, `lfsr_en`, `lfsr_seed_DV`, `timeout_err` = 0.
  - `response`, `seed_r`, counters = 0.
- **Reset mid-run:** abandons the run with no `done` pulse. The LFSR has no reset; the next SEED reinitialises it.
- **Latency:** `start` sampled at edge 0 → SEED in cycle 1 → STEP cycles 2..1+STEPS → `chal_valid` first high in cycle 2+STEPS.
- **Challenge handshake:** `chal_valid` stays high and `chal` stays constant until accepted. Zero-wait acceptance is legal: `chal_ready` already high gives a 1-cycle ISSUE.
- **Response capture:** `resp_valid` may arrive in the first WAIT cycle. The bit is captured on that edge.
- **Run timing:** minimum run length is 2 + NUM_CHAL·(STEPS+2) + 1 cycles from `start` to `done`.
- **Back-to-back runs:** `start` asserted in the cycle after `done` (IDLE) is accepted.

## Configuration
- **Macro:** `PUF_CHAL_TIMEOUT_EN`.
- **Defined:**
  - A wait counter clears on WAIT entry and increments each WAIT cycle without `resp_valid`.
  - When it reaches `TIMEOUT`, `timeout_err` ← 1 and the FSM goes to DONE. `done` pulses, and `response` holds the bits collected so far.
  - `timeout_err` stays set until the next accepted `start` or `rst`.
  - A `resp_valid` arriving in the same cycle the count reaches `TIMEOUT` wins: the bit is taken and no error is flagged.
- **Undefined:** no counter is built, `timeout_err` is tied 0, and WAIT waits indefinitely.

## Test plan
All scenarios use `NUM_BITS`=8, `NUM_CHAL`=4, `STEPS`=1.

- **Basic run:** seed 0x00, `chal_ready`=1, responses 1,0,1,1 → challenges 0x01, 0x03, 0x07, 0x0F in order; `response`=4'b1011; `done` one cycle; `busy` low after.
- **Lock-up seed:** seed 0xFF → identical challenge sequence to seed 0x00 (0x01 first).
- **Backpressure:** hold `chal_ready`=0 for 5 cycles on challenge 2 → `chal_valid` and `chal`=0x03 stable all 5 cycles; no LFSR step; final `response` unchanged.
- **Ignored strobes:**
  - `start` pulsed while busy → ignored.
  - `resp_valid` during STEP/ISSUE → not captured.
  - Count reaches exactly 4.
- **Mid-run reset:** `rst` asserted during WAIT of challenge 3 → next cycle all outputs at reset values; no `done`; a fresh run then yields the basic-run results.
- **Timeout** (`PUF_CHAL_TIMEOUT_EN`, `TIMEOUT`=10): no response on challenge 2 → `done` exactly 10 cycles after WAIT entry; `timeout_err`=1; `response`=4'b0001 (first bit 1); next `start` clears `timeout_err`.
